// File: rtl/lsu_pkg.sv
// Shared types and default geometry for the frame load/store unit.
// Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
package lsu_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  localparam int DEF_IMAGE_DIM       = 512;
  localparam int DEF_PIXEL_WIDTH     = 8;
  localparam int DEF_PIXELS_PER_BEAT = 16;
  localparam int DEF_NUM_BANKS       = 2;

endpackage

// File: rtl/frame_lsu_bank.sv
// One frame bank: simple dual-port RAM with registered read.
// Storage has no reset; only the control path around it does.
module frame_lsu_bank #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 16384,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_lsu.sv
// Multi-bank frame buffer: stream frames in, stream them back out
// in order, with a 2-deep skid FIFO hiding the RAM read latency.
module frame_lsu
  import lsu_pkg::*;
#(
  parameter int IMAGE_DIM       = DEF_IMAGE_DIM,
  parameter int PIXEL_WIDTH     = DEF_PIXEL_WIDTH,
  parameter int PIXELS_PER_BEAT = DEF_PIXELS_PER_BEAT,
  parameter int NUM_BANKS       = DEF_NUM_BANKS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] m_data,
  output logic                            m_last,
  output logic                            wr_frame_done,
  output logic                            rd_frame_done,
  output logic [$clog2(NUM_BANKS+1)-1:0]  full_banks
);

  localparam int DATA_WIDTH = PIXEL_WIDTH * PIXELS_PER_BEAT;
  localparam int MEM_DEPTH  = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CW = $clog2(NUM_BANKS + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  bank_state_t st [NUM_BANKS];
  bank_state_t wr_st, rd_st;

  logic [BW-1:0]         wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  issued_all;
  logic                  inflight, inflight_last;
  logic                  wr_done_q, rd_done_q;

  logic [1:0]            fifo_cnt;
  logic [DATA_WIDTH-1:0] f_data [2];
  logic [1:0]            f_last;

  logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
  logic [DATA_WIDTH-1:0] rd_data;

  logic       wr_fire, wr_last;
  logic       rd_fire, rd_last;
  logic       pop, pop_last;
  logic [2:0] occ;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  always_comb begin
    wr_st    = st[wr_bank];
    rd_st    = st[rd_bank];
    rd_data  = bank_rdata[rd_bank];
    s_ready  = rst_n && !flush &&
               (wr_st == BANK_EMPTY || wr_st == BANK_FILLING);
    wr_fire  = s_valid && s_ready;
    wr_last  = wr_fire && (wr_addr == LAST_ADDR);
    m_valid  = (fifo_cnt != 2'd0) && !flush;
    m_data   = f_data[0];
    m_last   = m_valid && f_last[0];
    pop      = m_valid && m_ready;
    pop_last = pop && f_last[0];
    // Occupancy the FIFO will have once this cycle's pop retires
    occ      = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    rd_fire  = !flush && (occ < 3'd2) &&
               (rd_st == BANK_FULL ||
                (rd_st == BANK_DRAINING && !issued_all));
    rd_last  = rd_fire && (rd_addr == LAST_ADDR);
  end

  always_comb begin
    full_banks = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (st[i] == BANK_FULL || st[i] == BANK_DRAINING)
        full_banks = full_banks + CW'(1);
    end
  end

  assign wr_frame_done = wr_done_q;
  assign rd_frame_done = rd_done_q;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    frame_lsu_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .we    (wr_fire && wr_bank == BW'(g)),
      .waddr (wr_addr),
      .wdata (s_data),
      .re    (rd_fire && rd_bank == BW'(g)),
      .raddr (rd_addr),
      .rdata (bank_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) st[i] <= BANK_EMPTY;
      wr_bank       <= '0;
      rd_bank       <= '0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      issued_all    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      fifo_cnt      <= 2'd0;
    end else if (flush) begin
      for (int i = 0; i < NUM_BANKS; i++) st[i] <= BANK_EMPTY;
      wr_bank       <= '0;
      rd_bank       <= '0;
      wr_addr       <= '0;
      rd_addr       <= '0;
      issued_all    <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_done_q     <= 1'b0;
      rd_done_q     <= 1'b0;
      fifo_cnt      <= 2'd0;
    end else begin
      // Write, issue and final pop always target distinct banks
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (wr_fire && wr_bank == BW'(i))
          st[i] <= wr_last ? BANK_FULL : BANK_FILLING;
        if (rd_fire && rd_bank == BW'(i) && rd_st == BANK_FULL)
          st[i] <= BANK_DRAINING;
        if (pop_last && rd_bank == BW'(i))
          st[i] <= BANK_EMPTY;
      end

      wr_done_q <= wr_last;
      rd_done_q <= pop_last;

      if (wr_fire) begin
        wr_addr <= wr_last ? '0 : wr_addr + 1'b1;
        if (wr_last) wr_bank <= next_bank(wr_bank);
      end

      if (rd_fire) begin
        rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
        if (rd_last) issued_all <= 1'b1;
      end
      inflight      <= rd_fire;
      inflight_last <= rd_last;

      if (pop_last) begin
        rd_bank    <= next_bank(rd_bank);
        issued_all <= 1'b0;
      end

      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

  // FIFO payload: head in slot 0, shifts forward on pop
  always_ff @(posedge clk) begin
    if (inflight && pop) begin
      if (fifo_cnt == 2'd1) begin
        f_data[0] <= rd_data;
        f_last[0] <= inflight_last;
      end else begin
        f_data[0] <= f_data[1];
        f_last[0] <= f_last[1];
        f_data[1] <= rd_data;
        f_last[1] <= inflight_last;
      end
    end else if (inflight) begin
      if (fifo_cnt == 2'd0) begin
        f_data[0] <= rd_data;
        f_last[0] <= inflight_last;
      end else begin
        f_data[1] <= rd_data;
        f_last[1] <= inflight_last;
      end
    end else if (pop) begin
      f_data[0] <= f_data[1];
      f_last[0] <= f_last[1];
    end
  end

endmodule

// File: doc/frame_lsu.md
FRAME_LSU -- requirements
Module: frame_lsu

Interface
REQ-001 SHALL have parameter IMAGE_DIM, default 512, frame width and height in pixels.
REQ-002 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-003 SHALL have parameter PIXELS_PER_BEAT, default 16, pixels per data beat.
REQ-004 SHALL have parameter NUM_BANKS, default 2, number of frame banks; legal range 1..4.
REQ-005 SHALL derive DATA_WIDTH = PIXEL_WIDTH*PIXELS_PER_BEAT, MEM_DEPTH = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT and ADDR_WIDTH = $clog2(MEM_DEPTH) as localparams.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port flush, input, 1, synchronous clear of all banks and pipelines.
REQ-009 SHALL have ports s_valid (in, 1), s_ready (out, 1) and s_data (in, DATA_WIDTH), forming the write stream.
REQ-010 SHALL have ports m_valid (out, 1), m_ready (in, 1), m_data (out, DATA_WIDTH) and m_last (out, 1, marks the final beat of a frame), forming the read stream.
REQ-011 SHALL have ports wr_frame_done and rd_frame_done, out, 1 each, single-cycle pulses.
REQ-012 SHALL have port full_banks, out, $clog2(NUM_BANKS+1), the count of banks in FULL or DRAINING.

Function
REQ-013 SHALL keep per-bank state EMPTY, FILLING, FULL, DRAINING; bank selection is round-robin starting at bank 0 for both the write and read sides.
REQ-014 SHALL assert s_ready iff the current write bank is EMPTY or FILLING and flush=0.
REQ-015 SHALL write accepted beats (s_valid&s_ready) at sequential addresses 0..MEM_DEPTH-1; a bank moves EMPTY->FILLING on its first beat.
REQ-016 SHALL, on acceptance of beat MEM_DEPTH-1, set the bank to FULL, pulse wr_frame_done in the following cycle, reset the write address to 0, and advance the write bank modulo NUM_BANKS.
REQ-017 SHALL issue reads from the current read bank (FULL->DRAINING on the first issue) at sequential addresses, with a 1-cycle synchronous RAM read latency.
REQ-018 SHALL buffer read data in a 2-entry output FIFO and issue a read only when fifo_count + inflight - (m_valid&m_ready) < 2, sustaining 1 beat/cycle under continuous m_ready.
REQ-019 SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-020 SHALL assert m_last with beat MEM_DEPTH-1; when that beat is popped, the bank becomes EMPTY, rd_frame_done pulses in the following cycle, and the read bank advances.
REQ-021 SHALL produce the first m_valid exactly 3 cycles after the cycle in which the last write beat of an otherwise-idle FULL frame is accepted.
REQ-022 SHALL apply simultaneous write-complete and read-complete events on different banks in the same cycle, with full_banks changing by net 0.
REQ-023 SHALL, for NUM_BANKS=1, strictly serialise operation: s_ready stays 0 from frame completion until rd_frame_done.
REQ-024 SHALL, on flush, in one cycle, set all banks EMPTY, zero both addresses and bank pointers, empty the FIFO, discard in-flight reads, and force m_valid=0; RAM contents are left unchanged.

Reset
REQ-025 SHALL, while rst_n=0, force all banks EMPTY, addresses and pointers to 0, and outputs s_ready=0, m_valid=0, m_last=0, wr_frame_done=0, rd_frame_done=0, full_banks=0; m_data is don't-care.
REQ-026 SHALL assert s_ready in the first cycle after rst_n rises; reset taken mid-frame discards the partial frame.

Structure
REQ-027 SHALL place the bank-state enum and the default parameter constants in a shared package, lsu_pkg.
REQ-028 SHALL instantiate sub-module frame_lsu_bank (one simple dual-port RAM, MEM_DEPTH x DATA_WIDTH, registered read with read enable, no reset on storage) NUM_BANKS times.

Verification (IMAGE_DIM=8, PIXELS_PER_BEAT=16, MEM_DEPTH=4, NUM_BANKS=2)
REQ-029 SHALL cover: write beats 0x10..0x13 with m_ready=1 -> wr_frame_done pulses, m_valid rises 3 cycles after beat 0x13, out 0x10..0x13 on consecutive cycles, m_last on 0x13, then rd_frame_done.
REQ-030 SHALL cover: write 3 frames with m_ready=0 -> s_ready drops after frame 2, full_banks=2; raising m_ready drains frames 1 and 2 in order and frame 3 is then accepted.
REQ-031 SHALL cover: m_ready toggling 1,0,1,0 during a read -> no beat lost or duplicated, and m_data stable while stalled.
REQ-032 SHALL cover: frame B completes in the same cycle frame A's last beat is popped -> both pulses fire and full_banks stays 1.
REQ-033 SHALL cover: flush at beat 2 of a drain -> m_valid=0 next cycle, full_banks=0, next frame read from bank 0.
REQ-034 SHALL cover: rst_n low for 1 cycle mid-write -> all outputs at reset values; a subsequent frame of 0x20..0x23 reads back exactly.
